control_unit: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the register-file/ALU datapath. Fetches 16-bit instructions from instruction memory, decodes them into the datapath control fields (`loadReg`, `readRegA`, `readRegB`, `Imm`, `op`, `selectImm`), gates register write-back, latches ALU flags and resolves conditional branches against them.

---
 rtl/control_unit.sv | 145 ++++++++++++++
 tb/tb_control_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode sequencer driving the register-file/ALU control fields.
// Define CTRL_HALT_EN to turn opcode 1111 into a sticky HALT; otherwise it is a NOP.
module control_unit #(
  parameter int PC_W = 16
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [15:0]     instr_data,
  input  logic            instr_valid,
  input  logic [4:0]      flags,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      loadReg,
  output logic [3:0]      readRegA,
  output logic [3:0]      readRegB,
  output logic [7:0]      Imm,
  output logic [7:0]      op,
  output logic            selectImm,
  output logic            wrEn,
  output logic            halted
);

  // state     | meaning
  // FETCH     | instr_req high, wait for instr_valid, capture IR
  // DECODE    | IR fields registered onto datapath controls
  // EXECUTE   | ALU settle cycle
  // WRITEBACK | wrEn pulse, latch flags, pc+1
  // BRANCH    | resolve Bcond against latched flags, update pc
  // HALT      | stopped until CLR
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, HALT} state_t;

  state_t          state;
  logic [15:0]     ir;
  logic [4:0]      flag_q;
  logic [3:0]      opc;
  logic            is_cmp;
  logic            is_nop;
  logic            cond_true;
  logic [PC_W-1:0] disp;

  assign opc    = ir[15:12];
  assign is_cmp = ((opc == 4'h0) && (ir[7:4] == 4'hB)) || (opc == 4'hB);
  assign is_nop = (opc == 4'hF);
  assign disp   = {{(PC_W-8){ir[7]}}, ir[7:0]};

  // flag_q = {C,L,F,Z,N}
  always_comb begin
    cond_true = 1'b0;
    case (ir[11:8])
      4'd0:    cond_true = flag_q[1];
      4'd1:    cond_true = !flag_q[1];
      4'd2:    cond_true = flag_q[4];
      4'd3:    cond_true = !flag_q[4];
      4'd4:    cond_true = flag_q[3];
      4'd5:    cond_true = !flag_q[3];
      4'd6:    cond_true = flag_q[2];
      4'd7:    cond_true = !flag_q[2];
      4'd8:    cond_true = flag_q[0];
      4'd9:    cond_true = !flag_q[0];
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

`ifndef CTRL_HALT_EN
  assign halted = 1'b0;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= FETCH;
      ir        <= '0;
      flag_q    <= '0;
      pc        <= '0;
      loadReg   <= '0;
      readRegA  <= '0;
      readRegB  <= '0;
      Imm       <= '0;
      op        <= '0;
      selectImm <= 1'b0;
      wrEn      <= 1'b0;
      instr_req <= 1'b1;
`ifdef CTRL_HALT_EN
      halted    <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir        <= instr_data;
            instr_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (opc == 4'hC) begin
            state <= BRANCH;
`ifdef CTRL_HALT_EN
          end else if (opc == 4'hF) begin
            halted <= 1'b1;
            state  <= HALT;
`endif
          end else begin
            if (opc == 4'h0) begin
              op        <= {4'h0, ir[7:4]};
              readRegB  <= ir[3:0];
              selectImm <= 1'b0;
              readRegA  <= ir[11:8];
              loadReg   <= ir[11:8];
            end else if (opc != 4'hF) begin
              op        <= {opc, 4'h0};
              Imm       <= ir[7:0];
              selectImm <= 1'b1;
              readRegA  <= ir[11:8];
              loadReg   <= ir[11:8];
            end
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          wrEn  <= !(is_cmp || is_nop);
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          wrEn      <= 1'b0;
          if (!is_nop) flag_q <= flags;
          pc        <= pc + PC_W'(1);
          instr_req <= 1'b1;
          state     <= FETCH;
        end
        BRANCH: begin
          pc        <= cond_true ? pc + disp : pc + PC_W'(1);
          instr_req <= 1'b1;
          state     <= FETCH;
        end
        HALT: state <= HALT;
        default: begin
          instr_req <= 1'b1;
          state     <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected retire records,
// a monitor pops one each time the sequencer returns to FETCH.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] instr_data = '0;
  logic        instr_valid = 1'b0;
  logic [4:0]  flags = '0;
  logic        instr_req;
  logic [15:0] pc;
  logic [3:0]  loadReg, readRegA, readRegB;
  logic [7:0]  Imm, op;
  logic        selectImm, wrEn, halted;

  control_unit #(.PC_W(16)) dut (
    .CLK(CLK), .CLR(CLR), .instr_data(instr_data), .instr_valid(instr_valid),
    .flags(flags), .instr_req(instr_req), .pc(pc), .loadReg(loadReg),
    .readRegA(readRegA), .readRegB(readRegB), .Imm(Imm), .op(op),
    .selectImm(selectImm), .wrEn(wrEn), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    bit          chk;
    logic [3:0]  lr, ra, rb;
    logic [7:0]  imm, op;
    bit          sel;
    logic [15:0] pc;
    int          busy;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: busy = non-FETCH cycles of the current instruction
  initial begin
    bit   prev_req = 1'b1;
    int   busy = 0, nwr = 0, wr_pos = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (CLR) begin
        prev_req = 1'b1; busy = 0; nwr = 0; wr_pos = 0;
      end else begin
        if (!instr_req) busy++;
        if (wrEn) begin nwr++; wr_pos = busy; end
        if (instr_req && !prev_req) begin
          if (q.size() == 0) begin
            check("unexpected_retire", 1, 0);
          end else begin
            e = q.pop_front();
            check("pc", pc, e.pc);
            check("busy_cycles", busy, e.busy);
            check("wr_count", nwr, e.wr);
            if (e.wr) check("wr_in_writeback", wr_pos, 3);
            if (e.chk) begin
              check("loadReg", loadReg, e.lr);
              check("readRegA", readRegA, e.ra);
              check("readRegB", readRegB, e.rb);
              check("Imm", Imm, e.imm);
              check("op", op, e.op);
              check("selectImm", selectImm, e.sel);
            end
          end
          busy = 0; nwr = 0;
        end
        prev_req = instr_req;
      end
    end
  end

  task automatic issue(input logic [15:0] ins, input exp_t e, input bit push);
    int n = 0;
    if (push) q.push_back(e);
    while (!instr_req && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) check("fetch_timeout", 0, 1);
    instr_data  = ins;
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge CLK); n++; end
    check("drain", q.size(), 0);
  endtask

  initial begin
    exp_t none;
    none = '{0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 16'h0000, 0};

    repeat (2) @(negedge CLK);
    check("rst_pc", pc, 0);
    check("rst_instr_req", instr_req, 1);
    check("rst_wrEn", wrEn, 0);
    check("rst_halted", halted, 0);
    check("rst_ctrl", {loadReg, readRegA, readRegB, Imm, op, selectImm}, 0);
    #1 CLR = 1'b0;

    // ADD R1,R2 ext 5
    issue(16'h0152, '{1, 1, 4'h1, 4'h1, 4'h2, 8'h00, 8'h05, 0, 16'h0001, 3}, 1);
    // register compare ext B, Z=1 latched
    flags = 5'b00010;
    issue(16'h01B2, '{0, 1, 4'h1, 4'h1, 4'h2, 8'h00, 8'h0B, 0, 16'h0002, 3}, 1);
    // BEQ -4 taken: 2-4 = FFFE
    issue(16'hC0FC, '{0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 16'hFFFE, 2}, 1);
    // immediate compare, Z=0 latched
    flags = 5'b00000;
    issue(16'hB105, '{0, 1, 4'h1, 4'h1, 4'h2, 8'h05, 8'hB0, 1, 16'hFFFF, 3}, 1);
    // BEQ not taken: FFFF+1 wraps to 0
    issue(16'hC0FC, '{0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 16'h0000, 2}, 1);
    // immediate op 0101 R3, 0xFE
    issue(16'h53FE, '{1, 1, 4'h3, 4'h3, 4'h2, 8'hFE, 8'h50, 1, 16'h0001, 3}, 1);
    drain();

    for (int i = 0; i < 3; i++) begin
      check("stall_req", instr_req, 1);
      check("stall_pc", pc, 16'h0001);
      check("stall_wrEn", wrEn, 0);
      @(negedge CLK);
    end
    // branch always +5 from 1
    issue(16'hCE05, '{0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 16'h0006, 2}, 1);
    drain();

    // CLR during WRITEBACK
    begin
      int n = 0;
      issue(16'h0152, none, 0);
      while (!wrEn && n < 20) begin @(negedge CLK); n++; end
      check("clr_reach_wb", wrEn, 1);
      #1 CLR = 1'b1;
      #1;
      check("clr_wrEn_async", wrEn, 0);
      check("clr_pc_async", pc, 0);
      check("clr_req_async", instr_req, 1);
      check("clr_loadReg", loadReg, 0);
      @(negedge CLK);
      #1 CLR = 1'b0;
    end
    issue(16'h0152, '{1, 1, 4'h1, 4'h1, 4'h2, 8'h00, 8'h05, 0, 16'h0001, 3}, 1);
    drain();

`ifdef CTRL_HALT_EN
    issue(16'hF000, none, 0);
    repeat (10) @(negedge CLK);
    check("halt_halted", halted, 1);
    check("halt_req", instr_req, 0);
    check("halt_wrEn", wrEn, 0);
    check("halt_pc", pc, 16'h0001);
`else
    issue(16'hF000, '{0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 16'h0002, 3}, 1);
    drain();
    check("nop_halted", halted, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
